id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage RV32I pipeline. Sits between the IF/ID register and the ID/EX register.
- Holds the 32x32 integer register file: written by write-back, read combinationally for rs1/rs2.
- Generates the sign-extended immediate and the main control bits.
- Detects load-use hazards and issues a stall plus bubble.
- All data outputs feed ID/EX directly.

---
 rtl/id_stage.sv | 139 +++++++++++++
 tb/tb_id_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file with write-through bypass,
// immediate generation, main control decode and load-use hazard detection.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_incr_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_wdata_i,
  input  logic            ex_memread_i,
  input  logic [4:0]      ex_rd_i,
  output logic [XLEN-1:0] pc_incr_o,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  output logic [XLEN-1:0] signextended_imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic [1:0]      alu_op_o,
  output logic            regwrite_o,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            memtoreg_o,
  output logic            alusrc_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            stall_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0] opcode;
  assign opcode     = instr_i[6:0];
  assign rs1_o      = instr_i[19:15];
  assign rs2_o      = instr_i[24:20];
  assign rd_o       = instr_i[11:7];
  assign funct3_o   = instr_i[14:12];
  assign funct7b5_o = instr_i[30];
  assign pc_incr_o  = pc_incr_i;

  // x0 has no storage; it is handled on the read side
  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (wb_we_i && wb_rd_i == 5'(i)) regs[i] <= wb_wdata_i;
    end
  end

  // Bypass lets a same-cycle write-back reach the operand; reset forces zero
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1_o == 5'(i)) rdata1_o = regs[i];
      if (rs2_o == 5'(i)) rdata2_o = regs[i];
    end
    if (wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == rs1_o) rdata1_o = wb_wdata_i;
    if (wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == rs2_o) rdata2_o = wb_wdata_i;
    if (!rst_n) begin
      rdata1_o = '0;
      rdata2_o = '0;
    end
  end

  always_comb begin
    signextended_imm_o = '0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        signextended_imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        signextended_imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        signextended_imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        signextended_imm_o = {instr_i[31:12], 12'b0};
      OPC_JAL:
        signextended_imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
      default: signextended_imm_o = '0;
    endcase
  end

  logic rw, mr, mw, m2r, br, jmp, ill, rs1_used, rs2_used, bubble;

  always_comb begin
    rw = 1'b0; mr = 1'b0; mw = 1'b0; m2r = 1'b0; br = 1'b0; jmp = 1'b0;
    alusrc_o = 1'b0;
    alu_op_o = 2'b00;
    ill      = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_OP:     begin rw = 1'b1; alu_op_o = 2'b10; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OP_IMM: begin rw = 1'b1; alusrc_o = 1'b1; alu_op_o = 2'b10; rs1_used = 1'b1; end
      OPC_LOAD:   begin rw = 1'b1; mr = 1'b1; m2r = 1'b1; alusrc_o = 1'b1; rs1_used = 1'b1; end
      OPC_STORE:  begin mw = 1'b1; alusrc_o = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_BRANCH: begin br = 1'b1; alu_op_o = 2'b01; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_JAL:    begin rw = 1'b1; alusrc_o = 1'b1; jmp = 1'b1; end
      OPC_JALR:   begin rw = 1'b1; alusrc_o = 1'b1; jmp = 1'b1; rs1_used = 1'b1; end
      OPC_LUI, OPC_AUIPC: begin rw = 1'b1; alusrc_o = 1'b1; end
      default:    ill = 1'b1;
    endcase
  end

  assign stall_o = ex_memread_i && (ex_rd_i != 5'd0) &&
                   ((rs1_used && ex_rd_i == rs1_o) || (rs2_used && ex_rd_i == rs2_o));

  // Bubble kills side effects only; operands and fields still flow to ID/EX
  assign bubble     = stall_o || flush_i;
  assign regwrite_o = rw  && !bubble;
  assign memread_o  = mr  && !bubble;
  assign memwrite_o = mw  && !bubble;
  assign memtoreg_o = m2r && !bubble;
  assign branch_o   = br  && !bubble;
  assign jump_o     = jmp && !bubble;
  assign illegal_o  = ill && !bubble;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus randomized decode
// traffic compared against a table-driven reference model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i, pc_incr_i, wb_wdata_i;
  logic        flush_i, wb_we_i, ex_memread_i;
  logic [4:0]  wb_rd_i, ex_rd_i;
  logic [31:0] pc_incr_o, rdata1_o, rdata2_o, signextended_imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic [1:0]  alu_op_o;
  logic        regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o, branch_o, jump_o;
  logic        stall_o, illegal_o;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_incr_i(pc_incr_i),
    .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_wdata_i(wb_wdata_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .pc_incr_o(pc_incr_o),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .signextended_imm_o(signextended_imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .alu_op_o(alu_op_o), .regwrite_o(regwrite_o),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o),
    .alusrc_o(alusrc_o), .branch_o(branch_o), .jump_o(jump_o),
    .stall_o(stall_o), .illegal_o(illegal_o)
  );

  logic [31:0] mregs [32];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
    if (wb_we_i && wb_rd_i == a) return wb_wdata_i;
    return mregs[a];
  endfunction

  // Full reference check of every output for the current inputs
  task automatic check_all();
    logic [6:0]  op;
    logic [31:0] ins, imm;
    logic [8:0]  c;   // {rw mr mw m2r asrc br j alu_op}
    logic        ill, u1, u2, stl, bub;
    ins = instr_i;
    op  = ins[6:0];
    ill = 1'b0; u1 = 1'b0; u2 = 1'b0;
    imm = 32'h0;
    case (op)
      7'b0110011: begin c = 9'b1000000_10; u1 = 1; u2 = 1; end
      7'b0010011: begin c = 9'b1000100_10; u1 = 1; imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0000011: begin c = 9'b1101100_00; u1 = 1; imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0100011: begin c = 9'b0010100_00; u1 = 1; u2 = 1;
                        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b1100011: begin c = 9'b0000010_01; u1 = 1; u2 = 1;
                        imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'b1101111: begin c = 9'b1000101_00;
                        imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'b1100111: begin c = 9'b1000101_00; u1 = 1; imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0110111, 7'b0010111: begin c = 9'b1000100_00; imm = {ins[31:12], 12'h000}; end
      default:    begin c = 9'b0; ill = 1'b1; end
    endcase
    stl = ex_memread_i && ex_rd_i != 0 &&
          ((u1 && ex_rd_i == ins[19:15]) || (u2 && ex_rd_i == ins[24:20]));
    bub = stl || flush_i;
    if (bub) begin
      c = c & 9'b0000100_11;
      ill = 1'b0;
    end
    check("pc_incr", pc_incr_o, pc_incr_i);
    check("rdata1", rdata1_o, model_read(ins[19:15]));
    check("rdata2", rdata2_o, model_read(ins[24:20]));
    check("imm", signextended_imm_o, imm);
    check("fields", {17'h0, rs1_o, rs2_o, rd_o}, {17'h0, ins[19:15], ins[24:20], ins[11:7]});
    check("funct", {28'h0, funct3_o, funct7b5_o}, {28'h0, ins[14:12], ins[30]});
    check("ctrl", {23'h0, regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o,
                   branch_o, jump_o, alu_op_o}, {23'h0, c});
    check("stall", {31'h0, stall_o}, {31'h0, stl});
    check("illegal", {31'h0, illegal_o}, {31'h0, ill});
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst_n && wb_we_i && wb_rd_i != 0) mregs[wb_rd_i] = wb_wdata_i;
  endtask

  task automatic idle_inputs();
    flush_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_wdata_i = 0;
    ex_memread_i = 0; ex_rd_i = 0;
  endtask

  logic [6:0] op_tab [12];

  initial begin
    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
               7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111, 7'b1110011};
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    rst_n = 0; idle_inputs();
    instr_i = 32'h000280B3; pc_incr_i = 32'h0000_1004;
    wb_we_i = 1; wb_rd_i = 5'd1; wb_wdata_i = 32'hAAAA_5555;
    #12;
    check_all();
    check("rst_rd1_zero", rdata1_o, 32'h0);
    check("rst_decode_rw", {31'h0, regwrite_o}, 32'h1);
    @(negedge clk); rst_n = 1; idle_inputs();

    // write x5, then read it back via add x1,x5,x0
    @(negedge clk); wb_we_i = 1; wb_rd_i = 5; wb_wdata_i = 32'hDEADBEEF;
    #1 check_all(); clock_edge();
    @(negedge clk); idle_inputs(); instr_i = 32'h000280B3;
    #1 check_all();
    check("add_rd1", rdata1_o, 32'hDEADBEEF);
    check("add_rd2", rdata2_o, 32'h0);
    check("add_aluop", {30'h0, alu_op_o}, 32'h2);
    clock_edge();

    // same-cycle bypass
    @(negedge clk); wb_we_i = 1; wb_rd_i = 3; wb_wdata_i = 32'h12345678; instr_i = 32'hFFF18213;
    #1 check_all();
    check("bypass_rd1", rdata1_o, 32'h12345678);
    check("addi_imm", signextended_imm_o, 32'hFFFFFFFF);
    check("addi_alusrc", {31'h0, alusrc_o}, 32'h1);
    clock_edge();

    // x0 protection
    @(negedge clk); wb_we_i = 1; wb_rd_i = 0; wb_wdata_i = 32'hFFFFFFFF; instr_i = 32'h00000013;
    #1 check_all(); check("x0_bypass", rdata1_o, 32'h0); clock_edge();
    @(negedge clk); idle_inputs();
    #1 check_all(); check("x0_read", rdata1_o, 32'h0); clock_edge();

    @(negedge clk); instr_i = 32'hFE208CE3;
    #1 check_all(); check("beq_imm", signextended_imm_o, 32'hFFFFFFF8);
    check("beq_br", {31'h0, branch_o}, 32'h1);
    @(negedge clk); instr_i = 32'h001000EF;
    #1 check_all(); check("jal_imm", signextended_imm_o, 32'h00000800);
    check("jal_j", {31'h0, jump_o}, 32'h1);
    @(negedge clk); instr_i = 32'h0020A623;
    #1 check_all(); check("sw_imm", signextended_imm_o, 32'h0000000C);
    check("sw_mw", {31'h0, memwrite_o}, 32'h1);

    // load-use hazard, with a same-register write-back that must still land
    @(negedge clk); ex_memread_i = 1; ex_rd_i = 5; instr_i = 32'h000280B3;
    wb_we_i = 1; wb_rd_i = 5; wb_wdata_i = 32'h0BAD_F00D;
    #1 check_all(); check("lu_stall", {31'h0, stall_o}, 32'h1);
    check("lu_rw", {31'h0, regwrite_o}, 32'h0);
    clock_edge();
    @(negedge clk); wb_we_i = 0; instr_i = 32'h000012B7;
    #1 check_all(); check("lui_nostall", {31'h0, stall_o}, 32'h0);
    @(negedge clk); idle_inputs(); instr_i = 32'h000280B3;
    #1 check_all(); check("stall_wb", rdata1_o, 32'h0BAD_F00D);

    @(negedge clk); instr_i = 32'h0000007F;
    #1 check_all(); check("ill", {31'h0, illegal_o}, 32'h1);
    @(negedge clk); flush_i = 1;
    #1 check_all(); check("ill_flush", {31'h0, illegal_o}, 32'h0);

    // randomized traffic with a mid-run asynchronous reset
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      instr_i = $urandom;
      instr_i[6:0]   = op_tab[$urandom_range(0, 11)];
      instr_i[19:15] = 5'($urandom_range(0, 7));
      instr_i[24:20] = 5'($urandom_range(0, 7));
      pc_incr_i    = $urandom;
      flush_i      = ($urandom_range(0, 7) == 0);
      wb_we_i      = $urandom_range(0, 1);
      wb_rd_i      = 5'($urandom_range(0, 7));
      wb_wdata_i   = $urandom;
      ex_memread_i = $urandom_range(0, 1);
      ex_rd_i      = 5'($urandom_range(0, 7));
      if (it == 200) begin
        wb_we_i = 1; wb_rd_i = 6; instr_i[19:15] = 5'd6;
        #2 rst_n = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        #1 check_all();
        check("rst_mid_rd1", rdata1_o, 32'h0);
        clock_edge();
        @(negedge clk); rst_n = 1; wb_we_i = 0;
        #1 check_all();
        check("rst_discard", rdata1_o, 32'h0);
      end else begin
        #1 check_all();
      end
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
